// File: rtl/maxnet_pkg.sv
// maxnet_pkg: shared error codes, FP field constants and loader state type.
// MAXNET_LOADER_DENORM_FLUSH_EN turns on flushing of subnormal words to +0.
package maxnet_pkg;
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_NEG  = 2'd1;
  localparam logic [1:0] ERR_NAN  = 2'd2;
  localparam logic [1:0] ERR_EPS  = 2'd3;
  localparam logic [7:0] EXP_ALL_ONES = 8'hFF;
  localparam int SIGN = 31;
  localparam logic [31:0] ONE_F32 = 32'h3F800000;
`ifdef MAXNET_LOADER_DENORM_FLUSH_EN
  localparam bit DENORM_FLUSH = 1'b1;
`else
  localparam bit DENORM_FLUSH = 1'b0;
`endif
  typedef enum logic [1:0] {ST_COLLECT, ST_HOLD, ST_ERR} state_t;
endpackage

// File: rtl/maxnet_f32_classify.sv
// maxnet_f32_classify: combinational IEEE-754 single field classifier and sanitiser.
module maxnet_f32_classify
  import maxnet_pkg::*;
(
  input  logic [31:0] word,
  output logic        is_nan_inf,
  output logic        is_neg,
  output logic        is_zero,
  output logic        is_subnormal,
  output logic [31:0] clean
);
  assign is_nan_inf   = word[30:23] == EXP_ALL_ONES;
  assign is_zero      = word[30:0] == 31'd0;
  assign is_subnormal = (word[30:23] == 8'd0) && !is_zero;
  assign is_neg       = word[SIGN] && !is_zero;
  // -0 always becomes +0; subnormals only when flushing is built in
  assign clean = (is_zero || (DENORM_FLUSH && is_subnormal)) ? '0 : word;
endmodule

// File: rtl/maxnet_input_loader.sv
// maxnet_input_loader: collects a1..a4 and epsilon serially, validates them and holds the set.
// Build with MAXNET_LOADER_DENORM_FLUSH_EN to flush subnormal inputs to zero.
module maxnet_input_loader
  import maxnet_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int NUM_IN = 4,
  parameter logic [WORD_W-1:0] EPS_MAX = 32'h3E800000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sw_clr,
  output logic [WORD_W-1:0] a1_init,
  output logic [WORD_W-1:0] a2_init,
  output logic [WORD_W-1:0] a3_init,
  output logic [WORD_W-1:0] a4_init,
  output logic [WORD_W-1:0] epsilon,
  output logic              init_valid,
  input  logic              init_accept,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [2:0]        word_cnt
);
  state_t state, state_n;
  logic [WORD_W-1:0] slot [NUM_IN+1];
  logic [WORD_W-1:0] clean;
  logic [1:0] code_q, word_code;
  logic nan_inf, neg, zero, sub, flushed, xfer, is_eps, eps_ok, last;
  maxnet_f32_classify u_cls (
    .word(in_data), .is_nan_inf(nan_inf), .is_neg(neg), .is_zero(zero),
    .is_subnormal(sub), .clean(clean)
  );
  assign in_ready   = state == ST_COLLECT;
  assign init_valid = state == ST_HOLD;
  assign err        = state == ST_ERR;
  assign err_code   = err ? code_q : ERR_NONE;
  assign a1_init    = slot[0];
  assign a2_init    = slot[1];
  assign a3_init    = slot[2];
  assign a4_init    = slot[3];
  assign epsilon    = slot[NUM_IN];
  assign xfer    = in_valid && in_ready && !sw_clr;
  assign is_eps  = word_cnt == 3'(NUM_IN);
  assign last    = xfer && is_eps;
  assign flushed = DENORM_FLUSH && sub;
  assign eps_ok  = !zero && !flushed && (clean < EPS_MAX);
  assign word_code = nan_inf ? ERR_NAN :
                     is_eps ? (eps_ok ? ERR_NONE : ERR_EPS) :
                     (neg && !flushed) ? ERR_NEG : ERR_NONE;
  always_comb begin
    state_n = state;
    if (sw_clr) state_n = ST_COLLECT;
    else if (last) state_n = (code_q != ERR_NONE || word_code != ERR_NONE) ? ST_ERR : ST_HOLD;
    else if (init_valid && init_accept) state_n = ST_COLLECT;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_COLLECT;
      word_cnt <= '0;
      code_q   <= ERR_NONE;
      for (int i = 0; i <= NUM_IN; i++) slot[i] <= '0;
    end else begin
      state <= state_n;
      if (sw_clr || (init_valid && init_accept)) begin
        word_cnt <= '0;
        code_q   <= ERR_NONE;
      end else if (xfer) begin
        word_cnt <= word_cnt + 3'd1;
        if (code_q == ERR_NONE) code_q <= word_code;
        for (int i = 0; i <= NUM_IN; i++) if (word_cnt == 3'(i)) slot[i] <= clean;
      end
    end
  end
endmodule

// File: tb/tb_maxnet_input_loader.sv
// tb_maxnet_input_loader: directed stimulus with a set-level reference model and literal spot checks.
module tb_maxnet_input_loader;
  logic clk = 0, rst = 1, in_valid = 0, sw_clr = 0, init_accept = 0;
  logic [31:0] in_data = '0;
  logic in_ready, init_valid, err;
  logic [31:0] a1_init, a2_init, a3_init, a4_init, epsilon;
  logic [1:0] err_code;
  logic [2:0] word_cnt;
  int n_cmp = 0, n_bad = 0;

  maxnet_input_loader dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sw_clr(sw_clr), .a1_init(a1_init), .a2_init(a2_init), .a3_init(a3_init),
    .a4_init(a4_init), .epsilon(epsilon), .init_valid(init_valid),
    .init_accept(init_accept), .err(err), .err_code(err_code), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  // model: phase 0 = gathering words, 1 = set presented, 2 = set rejected
  int m_phase = 0, m_cnt = 0, m_code = 0;
  logic [31:0] m_slot [5];

  function automatic logic [31:0] sanitise(input logic [31:0] w);
    int e = int'(w[30:23]);
    int m = int'(w[22:0]);
    if (w == 32'h80000000) return 32'h0;
`ifdef MAXNET_LOADER_DENORM_FLUSH_EN
    if (e == 0 && m != 0) return 32'h0;
`endif
    return w;
  endfunction

  function automatic int judge(input logic [31:0] w, input bit eps);
    logic [31:0] v = sanitise(w);
    if (v[30:23] == 8'd255) return 2;
    if (eps) return (v == 0 || v >= 32'h3E800000) ? 3 : 0;
    return (v[31] && v[30:0] != 0) ? 1 : 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_cnt = 0; m_code = 0;
      for (int i = 0; i < 5; i++) m_slot[i] = '0;
    end else if (sw_clr) begin
      m_phase = 0; m_cnt = 0; m_code = 0;
    end else if (m_phase == 0 && in_valid) begin
      int c;
      c = judge(in_data, m_cnt == 4);
      m_slot[m_cnt] = sanitise(in_data);
      if (m_code == 0) m_code = c;
      m_cnt++;
      if (m_cnt == 5) m_phase = (m_code != 0) ? 2 : 1;
    end else if (m_phase == 1 && init_accept) begin
      m_phase = 0; m_cnt = 0; m_code = 0;
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      cmp("in_ready", 32'(in_ready), 32'(m_phase == 0));
      cmp("init_valid", 32'(init_valid), 32'(m_phase == 1));
      cmp("err", 32'(err), 32'(m_phase == 2));
      cmp("err_code", 32'(err_code), (m_phase == 2) ? 32'(m_code) : 32'd0);
      cmp("word_cnt", 32'(word_cnt), 32'(m_cnt));
      cmp("a1", a1_init, m_slot[0]);
      cmp("a2", a2_init, m_slot[1]);
      cmp("a3", a3_init, m_slot[2]);
      cmp("a4", a4_init, m_slot[3]);
      cmp("eps", epsilon, m_slot[4]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [31:0] w0, w1, w2, w3, w4);
    logic [31:0] ws [5];
    ws = '{w0, w1, w2, w3, w4};
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_data = ws[i];
      tick();
    end
    in_valid = 0;
  endtask

  task automatic pulse_accept();
    init_accept = 1; tick(); init_accept = 0;
  endtask

  task automatic pulse_clr();
    sw_clr = 1; tick(); sw_clr = 0;
  endtask

  initial begin
    #1;
    cmp("rst_ready", 32'(in_ready), 32'd1);
    cmp("rst_valid", 32'(init_valid), 32'd0);
    cmp("rst_cnt", 32'(word_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 0;
    tick();
    send(maxnet_pkg::ONE_F32, 32'h40000000, 32'h3F000000, 32'h40400000, 32'h3DCCCCCD);
    cmp("lit_valid", 32'(init_valid), 32'd1);
    cmp("lit_ready", 32'(in_ready), 32'd0);
    cmp("lit_a1", a1_init, 32'h3F800000);
    cmp("lit_a4", a4_init, 32'h40400000);
    cmp("lit_eps", epsilon, 32'h3DCCCCCD);
    in_valid = 1; in_data = 32'hDEADBEEF; tick(); tick(); in_valid = 0;
    cmp("hold_cnt", 32'(word_cnt), 32'd5);
    cmp("hold_a1", a1_init, 32'h3F800000);
    pulse_accept();
    cmp("acc_ready", 32'(in_ready), 32'd1);
    cmp("acc_cnt", 32'(word_cnt), 32'd0);
    send(32'h80000000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3DCCCCCD);
    cmp("negzero_a1", a1_init, 32'h0);
    cmp("negzero_valid", 32'(init_valid), 32'd1);
    pulse_accept();
    send(32'h3F800000, 32'hBF800000, 32'h7FC00000, 32'h3F800000, 32'h3DCCCCCD);
    cmp("first_err", 32'(err), 32'd1);
    cmp("first_code", 32'(err_code), 32'd1);
    pulse_accept();
    cmp("err_sticky", 32'(err), 32'd1);
    pulse_clr();
    cmp("clr_err", 32'(err), 32'd0);
    send(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3E800000);
    cmp("eps_max_code", 32'(err_code), 32'd3);
    pulse_clr();
    send(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3E7FFFFF);
    cmp("eps_ok_valid", 32'(init_valid), 32'd1);
    pulse_accept();
    send(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h00000000);
    cmp("eps_zero_code", 32'(err_code), 32'd3);
    pulse_clr();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_data = 32'h40000000; tick();
    end
    sw_clr = 1; in_data = 32'h40800000; tick(); sw_clr = 0; in_valid = 0;
    cmp("clr_cnt", 32'(word_cnt), 32'd0);
    send(32'h40000000, 32'h3F800000, 32'h3F000000, 32'h40400000, 32'h3D800000);
    cmp("after_clr_valid", 32'(init_valid), 32'd1);
    cmp("after_clr_a1", a1_init, 32'h40000000);
    #1 rst = 1;
    #1;
    cmp("arst_valid", 32'(init_valid), 32'd0);
    cmp("arst_a1", a1_init, 32'h0);
    cmp("arst_eps", epsilon, 32'h0);
    cmp("arst_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #2 rst = 0;
    tick();
    send(32'h80000001, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3DCCCCCD);
`ifdef MAXNET_LOADER_DENORM_FLUSH_EN
    cmp("denorm_valid", 32'(init_valid), 32'd1);
    cmp("denorm_a1", a1_init, 32'h0);
`else
    cmp("denorm_code", 32'(err_code), 32'd1);
    cmp("denorm_a1", a1_init, 32'h80000001);
`endif
    pulse_clr();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
